// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide,
// sign fix-up, then a single-cycle register-file write-back.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state;
  logic [5:0]          cnt;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     ma, mb;
  logic [2*XLEN-1:0]   acc;
  logic                neg_q, neg_rem_q, special_q;

  // operand decode (IDLE only)
  logic                a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, spec_val;

  // iteration datapath
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_r;
  logic [XLEN+1:0]     div_diff;
  logic                div_ge;

  // fix-up datapath
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, result;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default: ;
    endcase
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;
    is_div   = funct3[2];
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    spec_val = '0;
    if (div_zero)
      spec_val = funct3[1] ? op_a : '1;
    else if (div_ovf)
      spec_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply keeps the multiplier in acc[low] and accumulates ma into acc[high];
  // divide keeps the dividend/quotient in acc[low] and the partial remainder in acc[high].
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
    div_r    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_r} - {2'b00, mb};
    div_ge   = ~div_diff[XLEN+1];
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
    if (special_q)
      result = acc[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q      <= funct3;
            rd_q      <= rd_addr;
            ma        <= mag_a;
            mb        <= mag_b;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            busy      <= 1'b1;
            cnt       <= '0;
            if (div_zero || div_ovf) begin
              // special result parked in acc so FIX writes it back unchanged
              special_q <= 1'b1;
              acc       <= {{XLEN{1'b0}}, spec_val};
              state     <= S_FIX;
            end else begin
              special_q <= 1'b0;
              acc       <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt == 6'd32) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + 6'd1;
            if (f3_q[2])
              acc <= {(div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0]),
                      acc[XLEN-2:0], div_ge};
            else
              acc <= {mul_sum, acc[XLEN-1:1]};
          end
        end
        S_FIX: begin
          wb_data <= result;
          wb_addr <= rd_q;
          wb_we   <= (rd_q != 5'd0);
          done    <= 1'b1;
          state   <= S_DONE;
        end
        default: begin
          done  <= 1'b0;
          wb_we <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write-backs queued at acceptance,
// popped and compared on the done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  addr;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rd_addr(rd_addr),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'b0, a});
    longint     ub = longint'({32'b0, b});
    logic [63:0] p;
    int         ia = a;
    int         ib = b;
    logic       ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives start across E0 and queues the expected write-back; returns just after E0's following negedge.
  task automatic launch(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f; rd_addr = rd; op_a = a; op_b = b;
    @(posedge clk);
    e.addr = rd; e.we = (rd != 0); e.data = exp;
    sbq.push_back(e);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %b want 1", busy);
    end
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_addr = 5'($urandom);
  endtask

  // Counts edges to the done pulse (exp_lat relative to the caller's position), compares write-back.
  task automatic wait_done(input string name, input int exp_lat, input bit tail);
    int   n = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && n < 100) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d (seen=%0d)", name, n, exp_lat, seen);
    end
    if (seen && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({busy, wb_we, wb_addr, wb_data} !== {1'b1, e.we, e.addr, e.data}) begin
        errors++;
        $display("FAIL %s_wb got busy=%b we=%b addr=%0d data=%h want busy=1 we=%b addr=%0d data=%h",
                 name, busy, wb_we, wb_addr, wb_data, e.we, e.addr, e.data);
      end
      if (tail) begin
        @(posedge clk); #1;
        checks++;
        if ({busy, done, wb_we, wb_data} !== {3'b000, e.data}) begin
          errors++;
          $display("FAIL %s_tail got busy=%b done=%b we=%b data=%h want 0 0 0 data=%h",
                   name, busy, done, wb_we, wb_data, e.data);
        end
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int lat);
    launch(f, rd, a, b, exp);
    wait_done(name, lat, 1'b1);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, wb_we, wb_addr, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b we=%b addr=%0d data=%h want all 0",
               busy, done, wb_we, wb_addr, wb_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul;
    run_op("mul",    3'b000, 5'd5, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",   3'b001, 5'd6, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu",  3'b011, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", 3'b010, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
  endtask

  task automatic test_div;
    run_op("div",  3'b100, 5'd9,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem",  3'b110, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu", 3'b101, 5'd11, 32'd100,       32'd7, 32'd14,        34);
    run_op("remu", 3'b111, 5'd12, 32'd100,       32'd7, 32'd2,         34);
  endtask

  task automatic test_special;
    run_op("divu_zero", 3'b101, 5'd13, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_zero",  3'b110, 5'd14, 32'h1234,      32'd0,         32'h1234,      1);
    run_op("div_ovf",   3'b100, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'b110, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
  endtask

  task automatic test_ignore_start;
    launch(3'b101, 5'd17, 32'd100, 32'd7, 32'd14);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rd_addr = 5'd18; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 29, 1'b1);
  endtask

  task automatic test_rd_zero;
    run_op("rd_zero", 3'b000, 5'd0, 32'd6, 32'd9, 32'd54, 34);
  endtask

  task automatic test_back_to_back;
    int   n = 0;
    exp_t e;
    launch(3'b000, 5'd1, 32'd3, 32'd4, 32'd12);
    wait_done("b2b_first", 34, 1'b0);
    start = 1'b1; funct3 = 3'b011; rd_addr = 5'd2; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    while (n < 5) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_cycle_ignore got busy=%b want 0", busy);
        end
      end else if (busy === 1'b1) begin
        break;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL b2b_accept_edge got %0d want 2", n);
    end
    e.addr = 5'd2; e.we = 1'b1; e.data = model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    sbq.push_back(e);
    start = 1'b0;
    wait_done("b2b_second", 34, 1'b1);
  endtask

  task automatic test_reset_mid_op;
    int  hits = 0;
    launch(3'b000, 5'd3, 32'd1000, 32'd1000, 32'd1_000_000);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, wb_we, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_abort got busy=%b done=%b we=%b data=%h want all 0", busy, done, wb_we, wb_data);
    end
    void'(sbq.pop_back());
    @(negedge clk); rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || wb_we === 1'b1 || busy === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL reset_no_wb got %0d active cycles want 0", hits);
    end
    run_op("after_reset", 3'b101, 5'd4, 32'd1000, 32'd33, 32'd30, 34);
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rd = 5'($urandom_range(1, 31));
      lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      run_op("random", f, rd, a, b, model(f, a, b), lat);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_ignore_start;
    test_rd_zero;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
